// File: rtl/i2c_frame_tx.sv
// Bit-level I2C master write engine: START, {addr,rw}, two data bytes with ACK slots, STOP.
// Optional macro I2C_ACK_CHECK_EN: a NACK aborts the frame and is reported on o_nack.
`timescale 1ns/1ps
module i2c_frame_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [6:0]  i_addr,
  input  logic        i_rw,
  input  logic [15:0] i_reg_data,
  output logic        o_finished,
  output logic        o_nack,
  output logic        o_sclk,
  inout  wire         o_sdat,
  output logic        o_oen
);

  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE} state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_q;
  logic [2:0]         r_bit;
  logic [1:0]         r_byte;
  logic [23:0]        r_shift;
  logic               r_sclk;
  logic               r_sda;
  logic               r_oen;
  logic               r_finished;
  logic               w_tick;
  logic               w_skip;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

`ifdef I2C_ACK_CHECK_EN
  logic r_nack;
  logic w_sda_nack;
  // Anything other than a solid low from the slave counts as NACK.
  assign w_sda_nack = (o_sdat !== 1'b0);
  assign w_skip     = r_nack;
  assign o_nack     = r_nack;
`else
  assign w_skip     = 1'b0;
  assign o_nack     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_q        <= 2'd0;
      r_bit      <= 3'd0;
      r_byte     <= 2'd0;
      r_shift    <= 24'd0;
      r_sclk     <= 1'b1;
      r_sda      <= 1'b1;
      r_oen      <= 1'b1;
      r_finished <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
      r_nack     <= 1'b0;
`endif
    end else begin
      r_finished <= 1'b0;
      if (r_state == S_IDLE || r_state == S_DONE || w_tick)
        r_div <= '0;
      else
        r_div <= r_div + DIV_W'(1);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shift <= {i_addr, i_rw, i_reg_data};
            r_q     <= 2'd0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_q == 2'd0) begin
              r_q   <= 2'd1;
              r_sda <= 1'b0;
            end else begin
              r_q     <= 2'd0;
              r_bit   <= 3'd0;
              r_byte  <= 2'd0;
              r_sclk  <= 1'b0;
              r_sda   <= r_shift[23];
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd1: r_sclk <= 1'b1;
              2'd3: begin
                r_sclk  <= 1'b0;
                r_shift <= {r_shift[22:0], 1'b0};
                if (r_bit == 3'd7) begin
                  r_bit   <= 3'd0;
                  r_oen   <= 1'b0;
                  r_state <= S_ACK;
                end else begin
                  r_bit <= r_bit + 3'd1;
                  r_sda <= r_shift[22];
                end
              end
              default: ;
            endcase
          end
        end
        S_ACK: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd1: r_sclk <= 1'b1;
              2'd2: begin
`ifdef I2C_ACK_CHECK_EN
                if (w_sda_nack) r_nack <= 1'b1;
`endif
              end
              2'd3: begin
                r_sclk <= 1'b0;
                r_oen  <= 1'b1;
                if (r_byte == 2'd2 || w_skip) begin
                  r_sda   <= 1'b0;
                  r_state <= S_STOP;
                end else begin
                  r_byte  <= r_byte + 2'd1;
                  r_sda   <= r_shift[23];
                  r_state <= S_DATA;
                end
              end
              default: ;
            endcase
          end
        end
        S_STOP: begin
          if (w_tick) begin
            case (r_q)
              2'd0: begin
                r_q    <= 2'd1;
                r_sclk <= 1'b1;
              end
              2'd1: begin
                r_q   <= 2'd2;
                r_sda <= 1'b1;
              end
              default: begin
                r_q        <= 2'd0;
                r_finished <= 1'b1;
                r_state    <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef I2C_ACK_CHECK_EN
          r_nack  <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sclk     = r_sclk;
  assign o_oen      = r_oen;
  assign o_finished = r_finished;
  assign o_sdat     = r_oen ? r_sda : 1'bz;

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Directed bench for i2c_frame_tx: two instances (CLK_DIV=4 and CLK_DIV=2) with a bus decoder.
`timescale 1ns/1ps
module tb_i2c_frame_tx;

  logic        clk;
  logic        rst_n;
  logic        start1, start2;
  logic [6:0]  addr;
  logic        rw;
  logic [15:0] data;
  logic        ack_en;
  logic        sel;

  logic fin1, nack1, scl1, oen1;
  logic fin2, nack2, scl2, oen2;
  wire  sda1, sda2;

  int n_tests = 0;
  int n_fail  = 0;

  pullup (sda1);
  pullup (sda2);
  assign sda1 = (ack_en && !oen1) ? 1'b0 : 1'bz;
  assign sda2 = (ack_en && !oen2) ? 1'b0 : 1'bz;

  i2c_frame_tx #(.CLK_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_addr(addr), .i_rw(rw),
    .i_reg_data(data), .o_finished(fin1), .o_nack(nack1), .o_sclk(scl1),
    .o_sdat(sda1), .o_oen(oen1)
  );

  i2c_frame_tx #(.CLK_DIV(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_addr(addr), .i_rw(rw),
    .i_reg_data(data), .o_finished(fin2), .o_nack(nack2), .o_sclk(scl2),
    .o_sdat(sda2), .o_oen(oen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus decoder on the selected instance; log: 1000=START, 1001=STOP, else {byte,ack}.
  logic m_scl, m_sda, m_oen, m_fin, m_nack;
  assign m_scl  = sel ? scl2 : scl1;
  assign m_sda  = sel ? sda2 : sda1;
  assign m_oen  = sel ? oen2 : oen1;
  assign m_fin  = sel ? fin2 : fin1;
  assign m_nack = sel ? nack2 : nack1;

  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic [8:0] sh = '0;
  int         bitn = 0;
  int         scl_edges = 0;
  int         oen_low = 0;
  int         fin_cnt = 0;
  int         log_q[$];

  always @(negedge clk) begin
    if (m_scl !== p_scl) scl_edges <= scl_edges + 1;
    if (m_oen === 1'b0)  oen_low   <= oen_low + 1;
    if (m_fin === 1'b1)  fin_cnt   <= fin_cnt + 1;
    if (p_scl && m_scl && p_sda && !m_sda) begin
      log_q.push_back(1000);
      bitn <= 0;
    end else if (p_scl && m_scl && !p_sda && m_sda) begin
      log_q.push_back(1001);
      bitn <= 0;
    end else if (!p_scl && m_scl) begin
      sh <= {sh[7:0], m_sda};
      if (bitn == 8) begin
        log_q.push_back(int'({sh[7:0], m_sda}));
        bitn <= 0;
      end else begin
        bitn <= bitn + 1;
      end
    end
    p_scl <= m_scl;
    p_sda <= m_sda;
  end

  // Launch one frame on the selected instance and wait (bounded) for o_finished.
  task automatic run_frame(input logic [15:0] d, output int cyc, output logic nk, output int base);
    data = d;
    base = log_q.size();
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    cyc = 0;
    nk  = 1'bx;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (m_fin === 1'b1) begin
        nk = m_nack;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int e0;
    rst_n = 1'b0; start1 = 1'b1; start2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (scl1 !== 1'b1) begin n_fail++; $display("FAIL reset_scl got=%b exp=1", scl1); end
    n_tests++; if (sda1 !== 1'b1) begin n_fail++; $display("FAIL reset_sda got=%b exp=1", sda1); end
    n_tests++; if (oen1 !== 1'b1) begin n_fail++; $display("FAIL reset_oen got=%b exp=1", oen1); end
    n_tests++; if (fin1 !== 1'b0) begin n_fail++; $display("FAIL reset_fin got=%b exp=0", fin1); end
    n_tests++; if (nack1 !== 1'b0) begin n_fail++; $display("FAIL reset_nack got=%b exp=0", nack1); end
    start1 = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    e0 = scl_edges;
    repeat (50) @(posedge clk);
    #1;
    n_tests++; if (scl_edges - e0 !== 0) begin n_fail++; $display("FAIL idle_scl_edges got=%0d exp=0", scl_edges - e0); end
  endtask

  task automatic test_full_frame;
    int cyc, base, o0, f0, got;
    logic nk;
    int exp[$];
    sel = 1'b0; ack_en = 1'b1; addr = 7'h1A; rw = 1'b0;
    o0 = oen_low; f0 = fin_cnt;
    run_frame(16'h1E00, cyc, nk, base);
    n_tests++; if (cyc !== 452) begin n_fail++; $display("FAIL full_latency got=%0d exp=452", cyc); end
    n_tests++; if (nk !== 1'b0) begin n_fail++; $display("FAIL full_nack got=%b exp=0", nk); end
    exp = '{1000, 'h68, 'h3C, 'h00, 1001};
    n_tests++; if (log_q.size() - base !== exp.size()) begin n_fail++; $display("FAIL full_events got=%0d exp=%0d", log_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL full_decode[%0d] got=%0h exp=%0h", i, got, exp[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (oen_low - o0 !== 48) begin n_fail++; $display("FAIL full_oen_low got=%0d exp=48", oen_low - o0); end
    n_tests++; if (fin_cnt - f0 !== 1) begin n_fail++; $display("FAIL full_fin_pulses got=%0d exp=1", fin_cnt - f0); end
  endtask

  task automatic test_addr_nack;
    int cyc, base, o0, got;
    logic nk;
    int exp[$];
    sel = 1'b0; ack_en = 1'b0; addr = 7'h1A; rw = 1'b0;
    o0 = oen_low;
    run_frame(16'h1E00, cyc, nk, base);
`ifdef I2C_ACK_CHECK_EN
    n_tests++; if (cyc !== 164) begin n_fail++; $display("FAIL nack_latency got=%0d exp=164", cyc); end
    n_tests++; if (nk !== 1'b1) begin n_fail++; $display("FAIL nack_flag got=%b exp=1", nk); end
    exp = '{1000, 'h69, 1001};
`else
    n_tests++; if (cyc !== 452) begin n_fail++; $display("FAIL nack_latency got=%0d exp=452", cyc); end
    n_tests++; if (nk !== 1'b0) begin n_fail++; $display("FAIL nack_flag got=%b exp=0", nk); end
    exp = '{1000, 'h69, 'h3D, 'h01, 1001};
`endif
    n_tests++; if (log_q.size() - base !== exp.size()) begin n_fail++; $display("FAIL nack_events got=%0d exp=%0d", log_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL nack_decode[%0d] got=%0h exp=%0h", i, got, exp[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
`ifdef I2C_ACK_CHECK_EN
    n_tests++; if (oen_low - o0 !== 16) begin n_fail++; $display("FAIL nack_oen_low got=%0d exp=16", oen_low - o0); end
`else
    n_tests++; if (oen_low - o0 !== 48) begin n_fail++; $display("FAIL nack_oen_low got=%0d exp=48", oen_low - o0); end
`endif
    ack_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    int cyc, base, f0, got;
    logic nk;
    int exp[$];
    sel = 1'b0; ack_en = 1'b1; addr = 7'h1A; rw = 1'b0;
    f0 = fin_cnt;
    base = log_q.size();
    data = 16'h1E00;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    start1 = 1'b1; data = 16'hFFFF; addr = 7'h7F; rw = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 101;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (fin1 === 1'b1) break;
    end
    n_tests++; if (cyc !== 452) begin n_fail++; $display("FAIL busy_latency got=%0d exp=452", cyc); end
    exp = '{1000, 'h68, 'h3C, 'h00, 1001};
    n_tests++; if (log_q.size() - base !== exp.size()) begin n_fail++; $display("FAIL busy_events got=%0d exp=%0d", log_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL busy_decode[%0d] got=%0h exp=%0h", i, got, exp[i]); end
    end
    addr = 7'h1A; rw = 1'b0;
    @(posedge clk); #1;
    run_frame(16'h0815, cyc, nk, base);
    n_tests++; if (cyc !== 452) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=452", cyc); end
    exp = '{1000, 'h68, 'h10, 'h2A, 1001};
    n_tests++; if (log_q.size() - base !== exp.size()) begin n_fail++; $display("FAIL b2b_events got=%0d exp=%0d", log_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL b2b_decode[%0d] got=%0h exp=%0h", i, got, exp[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (fin_cnt - f0 !== 2) begin n_fail++; $display("FAIL b2b_fin_pulses got=%0d exp=2", fin_cnt - f0); end
  endtask

  task automatic test_reset_mid_byte;
    int cyc, base, f0, got;
    logic nk;
    int exp[$];
    sel = 1'b0; ack_en = 1'b1; addr = 7'h1A; rw = 1'b0;
    f0 = fin_cnt;
    data = 16'h1E00;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    // 238 cycles in: quarter 59 = second byte, bit 5, SCL-low phase.
    repeat (238) @(posedge clk);
    #1;
    n_tests++; if (scl1 !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_scl got=%b exp=0", scl1); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (scl1 !== 1'b1) begin n_fail++; $display("FAIL midrst_scl got=%b exp=1", scl1); end
    n_tests++; if (sda1 !== 1'b1) begin n_fail++; $display("FAIL midrst_sda got=%b exp=1", sda1); end
    n_tests++; if (oen1 !== 1'b1) begin n_fail++; $display("FAIL midrst_oen got=%b exp=1", oen1); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    n_tests++; if (fin_cnt - f0 !== 0) begin n_fail++; $display("FAIL midrst_fin_pulses got=%0d exp=0", fin_cnt - f0); end
    run_frame(16'h1E00, cyc, nk, base);
    n_tests++; if (cyc !== 452) begin n_fail++; $display("FAIL midrst_restart_latency got=%0d exp=452", cyc); end
    exp = '{1000, 'h68, 'h3C, 'h00, 1001};
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL midrst_decode[%0d] got=%0h exp=%0h", i, got, exp[i]); end
    end
  endtask

  task automatic test_min_div;
    int cyc, base, o0, got;
    logic nk;
    int exp[$];
    sel = 1'b1; ack_en = 1'b1; addr = 7'h1A; rw = 1'b0;
    @(posedge clk); #1;
    o0 = oen_low;
    run_frame(16'h1201, cyc, nk, base);
    n_tests++; if (cyc !== 226) begin n_fail++; $display("FAIL div2_latency got=%0d exp=226", cyc); end
    n_tests++; if (nk !== 1'b0) begin n_fail++; $display("FAIL div2_nack got=%b exp=0", nk); end
    exp = '{1000, 'h68, 'h24, 'h02, 1001};
    n_tests++; if (log_q.size() - base !== exp.size()) begin n_fail++; $display("FAIL div2_events got=%0d exp=%0d", log_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL div2_decode[%0d] got=%0h exp=%0h", i, got, exp[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (oen_low - o0 !== 24) begin n_fail++; $display("FAIL div2_oen_low got=%0d exp=24", oen_low - o0); end
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    addr = 7'h1A; rw = 1'b0; data = 16'h0000;
    ack_en = 1'b1; sel = 1'b0;
    test_reset();
    test_full_frame();
    test_addr_nack();
    test_back_to_back();
    test_reset_mid_byte();
    test_min_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
